dmem_responder: RTL and testbench

- Data-memory responder for the pipelined core's MEM-stage port (mren/mwen/addr/mwdata in, mrdata out).
- Single-ported word array behind a small posted-write buffer:
  - core reads always win the array port;
  - buffered writes drain into the array on cycles with no read;
  - reads forward from the youngest matching buffered write.
- Sits at top level beside the core and replaces the bench-side memory model for data accesses.

---
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: single-ported word array behind a posted-write FIFO with
// read forwarding. Define DMEM_ALIGN_CHK_EN to flag and suppress misaligned accesses.
module dmem_responder #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned AW       = 12,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mren,
  input  logic                        mwen,
  input  logic [XLEN-1:0]             addr,
  input  logic [XLEN-1:0]             mwdata,
  output logic [XLEN-1:0]             mrdata,
  output logic                        wb_empty,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        err_ovf,
  output logic                        err_mis
);

  localparam int unsigned OFF = $clog2(XLEN/8);
  localparam int unsigned PW  = $clog2(WB_DEPTH);
  localparam int unsigned CW  = PW + 1;

  logic [XLEN-1:0] mem     [2**AW];
  logic [AW-1:0]   wb_idx  [WB_DEPTH];
  logic [XLEN-1:0] wb_data [WB_DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [AW-1:0]   idx;
  logic            mis;
  logic            full;
  logic            enq;
  logic            deq;
  logic            ovf;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic [PW-1:0]   slot;
  logic            unused_addr;

  assign idx         = addr[AW+OFF-1:OFF];
  assign unused_addr = ^{addr[XLEN-1:AW+OFF], addr[OFF-1:0]};

`ifdef DMEM_ALIGN_CHK_EN
  assign mis = (addr[OFF-1:0] != '0);
`else
  assign mis = 1'b0;
`endif

  assign full     = (wb_count == CW'(WB_DEPTH));
  assign wb_empty = (wb_count == '0);

  // Without a read, a full buffer drains its head on the same edge, so the write always fits.
  assign deq = !mren && (wb_count != '0);
  assign enq = mwen && !mis && (!mren || !full);
  assign ovf = mwen && !mis && mren && full;

  // Scan oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if ((CW'(k) < wb_count) && (wb_idx[slot] == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[slot];
      end
    end
  end

  always_comb begin
    mrdata = '0;
    if (mren && !mis) begin
      mrdata = fwd_hit ? fwd_data : mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (deq) begin
      mem[wb_idx[rd_ptr]] <= wb_data[rd_ptr];
    end
    if (enq) begin
      wb_idx[wr_ptr]  <= idx;
      wb_data[wr_ptr] <= mwdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_count <= '0;
      err_ovf  <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      wb_count <= wb_count + CW'(enq) - CW'(deq);
      if (ovf) err_ovf <= 1'b1;
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mis <= 1'b0;
    end else if ((mren || mwen) && mis) begin
      err_mis <= 1'b1;
    end
  end
`else
  assign err_mis = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (XLEN=64, AW=12, WB_DEPTH=4).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mren;
  logic        mwen;
  logic [63:0] addr;
  logic [63:0] mwdata;
  logic [63:0] mrdata;
  logic        wb_empty;
  logic [2:0]  wb_count;
  logic        err_ovf;
  logic        err_mis;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.XLEN(64), .AW(12), .WB_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mren     (mren),
    .mwen     (mwen),
    .addr     (addr),
    .mwdata   (mwdata),
    .mrdata   (mrdata),
    .wb_empty (wb_empty),
    .wb_count (wb_count),
    .err_ovf  (err_ovf),
    .err_mis  (err_mis)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] wa(input int unsigned i);
    return 64'h8000_0000 + 64'(i) * 64'd8;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
    mren = r; mwen = w; addr = a; mwdata = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 64'h0, 64'h0);
    #10;
    check("rst_count", 64'(wb_count), 64'd0);
    check("rst_empty", 64'(wb_empty), 64'd1);
    check("rst_ovf",   64'(err_ovf),  64'd0);
    check("rst_mis",   64'(err_mis),  64'd0);
    rst_n = 1'b1;
    tick();

    // Posted write, drain, read back from array
    drive(0, 1, 64'h8000_0010, 64'hDEAD_BEEF);
    tick();
    drive(0, 0, 64'h0, 64'h0);
    check("w1_count1", 64'(wb_count), 64'd1);
    check("idle_rdata0", mrdata, 64'd0);
    tick();
    check("w1_count0", 64'(wb_count), 64'd0);
    check("w1_empty",  64'(wb_empty), 64'd1);
    drive(1, 0, 64'h8000_0010, 64'h0);
    check("w1_read", mrdata, 64'hDEAD_BEEF);
    tick();

    // Reads block drain; forwarding supplies data
    drive(0, 1, wa(5), 64'h11);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, wa(5), 64'h0);
      check("fwd5_data", mrdata, 64'h11);
      tick();
      check("fwd5_count", 64'(wb_count), 64'd1);
    end
    drive(0, 0, 64'h0, 64'h0);
    tick();
    check("fwd5_drained", 64'(wb_count), 64'd0);
    drive(1, 0, wa(5), 64'h0);
    check("arr5_read", mrdata, 64'h11);

    // Youngest wins; same-cycle write not forwarded
    drive(1, 1, wa(7), 64'hA);
    tick();
    drive(1, 1, wa(7), 64'hB);
    check("no_same_cycle_fwd", mrdata, 64'hA);
    tick();
    drive(1, 0, wa(7), 64'h0);
    check("youngest_wins", mrdata, 64'hB);
    check("dup_count2", 64'(wb_count), 64'd2);
    tick();
    drive(0, 0, 64'h0, 64'h0);
    tick();
    check("dup_count1", 64'(wb_count), 64'd1);
    tick();
    check("dup_count0", 64'(wb_count), 64'd0);
    drive(1, 0, wa(7), 64'h0);
    check("dup_array_last", mrdata, 64'hB);
    tick();

    // Fill with reads, overflow drop, then full write without read
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, wa(8 + i), 64'h100 + 64'(i));
      tick();
    end
    check("fill_count4", 64'(wb_count), 64'd4);
    check("fill_no_ovf", 64'(err_ovf), 64'd0);
    drive(1, 1, wa(12), 64'h555);
    tick();
    check("ovf_set", 64'(err_ovf), 64'd1);
    check("ovf_count4", 64'(wb_count), 64'd4);
    drive(0, 1, wa(12), 64'h5C);
    tick();
    check("full_wr_count4", 64'(wb_count), 64'd4);
    drive(1, 0, wa(8), 64'h0);
    check("head_in_array", mrdata, 64'h100);
    drive(1, 0, wa(12), 64'h0);
    check("full_wr_fwd", mrdata, 64'h5C);
    drive(1, 0, wa(11), 64'h0);
    check("fwd11", mrdata, 64'h103);
    drive(0, 0, 64'h0, 64'h0);
    for (int i = 0; i < 4; i++) tick();
    check("fill_drained", 64'(wb_count), 64'd0);
    check("ovf_sticky", 64'(err_ovf), 64'd1);

    // Async reset mid-drain discards pending writes
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, wa(20 + i), 64'hA0 + 64'(i));
      tick();
    end
    drive(0, 0, 64'h0, 64'h0);
    tick();
    check("pre_count0", 64'(wb_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, wa(20 + i), 64'hB0 + 64'(i));
      if (i == 0) check("old20", mrdata, 64'hA0);
      tick();
    end
    check("pend_count3", 64'(wb_count), 64'd3);
    drive(0, 0, 64'h0, 64'h0);
    tick();
    check("pend_count2", 64'(wb_count), 64'd2);
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(wb_count), 64'd0);
    check("arst_empty", 64'(wb_empty), 64'd1);
    check("arst_ovf",   64'(err_ovf),  64'd0);
    rst_n = 1'b1;
    drive(1, 0, wa(20), 64'h0);
    check("drained20", mrdata, 64'hB0);
    drive(1, 0, wa(21), 64'h0);
    check("old21", mrdata, 64'hA1);
    drive(1, 0, wa(22), 64'h0);
    check("old22", mrdata, 64'hA2);
    tick();

    // Misaligned access
    drive(0, 1, 64'h8000_0004, 64'h77);
    tick();
    drive(1, 0, 64'h8000_0004, 64'h0);
`ifdef DMEM_ALIGN_CHK_EN
    check("mis_count", 64'(wb_count), 64'd0);
    check("mis_flag",  64'(err_mis),  64'd1);
    check("mis_rdata", mrdata, 64'd0);
`else
    check("mis_count", 64'(wb_count), 64'd1);
    check("mis_flag",  64'(err_mis),  64'd0);
    check("mis_rdata", mrdata, 64'h77);
    drive(1, 0, 64'h8000_0000, 64'h0);
    check("idx0_rdata", mrdata, 64'h77);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
